// File: rtl/video_pgen_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package  : video_pgen_pkg                                              |
// | Desc     : Shared types, colour-bar table and pixel packing helper for |
// |            the AXI4-Stream video pattern generator.                    |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
package video_pgen_pkg;

    typedef enum logic [1:0] {
        MODE_GRADIENT = 2'd0,
        MODE_SOLID    = 2'd1,
        MODE_BARS     = 2'd2,
        MODE_CHECKER  = 2'd3
    } pgen_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } pgen_state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb8_t;

    // Widest packed pixel supported (three 16-bit components).
    localparam int c_PIX_MAX_W = 48;

    localparam rgb8_t BAR_LUT [8] = '{
        '{8'hFF, 8'hFF, 8'hFF},   // white
        '{8'hFF, 8'hFF, 8'h00},   // yellow
        '{8'h00, 8'hFF, 8'hFF},   // cyan
        '{8'h00, 8'hFF, 8'h00},   // green
        '{8'hFF, 8'h00, 8'hFF},   // magenta
        '{8'hFF, 8'h00, 8'h00},   // red
        '{8'h00, 8'h00, 8'hFF},   // blue
        '{8'h00, 8'h00, 8'h00}    // black
    };

    // Components in G,B,R order from the LSB; the 8-bit value occupies the
    // MSBs of each comp_w-bit field.
    function automatic logic [c_PIX_MAX_W-1:0] pack_pixel(input rgb8_t px, input int comp_w);
        logic [c_PIX_MAX_W-1:0] v;
        v = '0;
        v[comp_w - 8 +: 8]     = px.g;
        v[2 * comp_w - 8 +: 8] = px.b;
        v[3 * comp_w - 8 +: 8] = px.r;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vpgen_lfsr16.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : vpgen_lfsr16                                                |
// | Desc     : 16-bit Fibonacci LFSR (taps 16,14,13,11) driving pseudo-    |
// |            random valid bubbles in the pattern generator.              |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module vpgen_lfsr16 (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        i_clken,
    input  logic        i_sw_reset,
    output logic [15:0] o_lfsr
);

    localparam logic [15:0] c_SEED = 16'hACE1;

    logic [15:0] r_lfsr;
    logic        w_fb;

    assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_lfsr <= c_SEED;
        end else if (i_clken) begin
            r_lfsr <= i_sw_reset ? c_SEED : {r_lfsr[14:0], w_fb};
        end
    end

    assign o_lfsr = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/axis_video_pattern_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : axis_video_pattern_gen                                      |
// | Desc     : AXI4-Stream test-pattern source (gradient, solid, bars,     |
// |            checker) with SOF/EOL framing. VIDEO_PGEN_STALL_EN adds     |
// |            LFSR-driven valid bubbles.                                  |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module axis_video_pattern_gen #(
    parameter int H_ACTIVE     = 1920,
    parameter int V_ACTIVE     = 1080,
    parameter int PIX_PER_BEAT = 1,
    parameter int COMP_W       = 10,
    parameter int TDATA_W      = 64,
    parameter int FRAME_GAP    = 0,
    parameter int CHK_LOG2     = 5
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               aclken,
    input  logic               enable,
    input  logic               sw_reset,
    input  logic [1:0]         mode,
    input  logic [23:0]        solid_rgb,
    output logic [TDATA_W-1:0] m_axis_video_tdata,
    output logic               m_axis_video_tvalid,
    input  logic               m_axis_video_tready,
    output logic               m_axis_video_tuser,
    output logic               m_axis_video_tlast,
    output logic               frame_done,
    output logic [15:0]        frame_count,
    output logic               busy
);

    import video_pgen_pkg::*;

    localparam int c_PIXW  = 3 * COMP_W;
    localparam int c_XW    = $clog2(H_ACTIVE + 1);
    localparam int c_YW    = $clog2(V_ACTIVE + 1);
    localparam int c_GW    = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
    localparam int c_BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam bit c_NO_GAP = (FRAME_GAP == 0);

    localparam logic [c_XW-1:0] c_X_STEP = c_XW'(PIX_PER_BEAT);
    localparam logic [c_XW-1:0] c_X_LAST = c_XW'(H_ACTIVE - PIX_PER_BEAT);
    localparam logic [c_YW-1:0] c_Y_ONE  = c_YW'(1);
    localparam logic [c_YW-1:0] c_Y_LAST = c_YW'(V_ACTIVE - 1);
    localparam logic [c_GW-1:0] c_G_ONE  = c_GW'(1);
    localparam logic [c_GW-1:0] c_G_LAST = c_GW'(FRAME_GAP - 1);
    localparam logic [7:0]      c_K_STEP = 8'(PIX_PER_BEAT);
    localparam rgb8_t           c_BASE0  = '{8'hFF, 8'hFF, 8'hFF};

    pgen_state_e        r_state, w_state_nxt;
    pgen_mode_e         r_mode, w_mode;
    rgb8_t              r_base, w_base, r_solid, w_solid;
    logic [c_XW-1:0]    r_x;
    logic [c_YW-1:0]    r_y;
    logic [c_GW-1:0]    r_gap;
    logic               r_all_loaded, r_eof;
    logic [TDATA_W-1:0] r_tdata, w_tdata;
    logic               r_tvalid, r_tuser, r_tlast, r_frame_done;
    logic [15:0]        r_frame_count;
    logic               w_xfer, w_frame_end, w_room, w_sof, w_line_last, w_frame_last;
    logic               w_load_req, w_load, w_bubble;

    assign w_xfer       = r_tvalid & m_axis_video_tready & aclken;
    assign w_frame_end  = w_xfer & r_eof;
    assign w_room       = ~r_tvalid | w_xfer;
    assign w_sof        = (r_x == '0) && (r_y == '0);
    assign w_line_last  = (r_x == c_X_LAST);
    assign w_frame_last = w_line_last && (r_y == c_Y_LAST);

    // The SOF beat uses live mode/colour inputs; later beats use the copies latched with it.
    assign w_mode  = w_sof ? pgen_mode_e'(mode) : r_mode;
    assign w_solid = w_sof ? rgb8_t'(solid_rgb) : r_solid;
    assign w_base  = w_sof ? c_BASE0 : r_base;

`ifdef VIDEO_PGEN_STALL_EN
    logic [15:0] w_lfsr;

    vpgen_lfsr16 u_lfsr (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .i_clken    (aclken),
        .i_sw_reset (sw_reset),
        .o_lfsr     (w_lfsr)
    );

    // A bubble only postpones loading the next beat; a presented beat stays valid.
    assign w_bubble = (r_state == RUN) && (w_lfsr[1:0] == 2'b00);
`else
    assign w_bubble = 1'b0;
`endif

    assign w_load = w_load_req & ~w_bubble;

    function automatic rgb8_t pixel_at(input pgen_mode_e m, input rgb8_t base,
                                       input rgb8_t solid, input logic [31:0] px,
                                       input logic [31:0] py, input logic [7:0] k);
        rgb8_t       c;
        logic [31:0] idx;
        logic [31:0] chk;
        c = '0;
        case (m)
            MODE_GRADIENT: begin
                c.r = base.r - k;
                c.g = base.g + k;
                c.b = base.b - {k[6:0], 1'b0};
            end
            MODE_SOLID: c = solid;
            MODE_BARS: begin
                idx = px / c_BAR_W;
                if (idx > 32'd7) idx = 32'd7;
                c = BAR_LUT[idx[2:0]];
            end
            MODE_CHECKER: begin
                chk = (px >> CHK_LOG2) ^ (py >> CHK_LOG2);
                c   = chk[0] ? '{8'h00, 8'h00, 8'h00} : '{8'hFF, 8'hFF, 8'hFF};
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        w_tdata = '0;
        for (int p = 0; p < PIX_PER_BEAT; p++) begin
            w_tdata[p * c_PIXW +: c_PIXW] = c_PIXW'(pack_pixel(
                pixel_at(w_mode, w_base, w_solid, 32'(r_x) + 32'(p), 32'(r_y), 8'(p)),
                COMP_W));
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_req  = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable) w_state_nxt = RUN;
            end
            RUN: begin
                // With no gap, the next SOF beat loads on the same edge the final beat leaves.
                w_load_req = w_room && (!r_all_loaded || (w_frame_end && c_NO_GAP && enable));
                if (w_frame_end) begin
                    if (!c_NO_GAP)   w_state_nxt = GAP;
                    else if (enable) w_state_nxt = RUN;
                    else             w_state_nxt = IDLE;
                end
            end
            GAP: begin
                if (r_gap == c_G_LAST) w_state_nxt = enable ? RUN : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state       <= IDLE;
            r_mode        <= MODE_GRADIENT;
            r_base        <= c_BASE0;
            r_solid       <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_gap         <= '0;
            r_all_loaded  <= 1'b0;
            r_eof         <= 1'b0;
            r_tdata       <= '0;
            r_tvalid      <= 1'b0;
            r_tuser       <= 1'b0;
            r_tlast       <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
        end else if (aclken) begin
            r_frame_done <= 1'b0;
            if (sw_reset) begin
                r_state      <= IDLE;
                r_base       <= c_BASE0;
                r_x          <= '0;
                r_y          <= '0;
                r_gap        <= '0;
                r_all_loaded <= 1'b0;
                r_eof        <= 1'b0;
                r_tdata      <= '0;
                r_tvalid     <= 1'b0;
                r_tuser      <= 1'b0;
                r_tlast      <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_gap   <= (r_state == GAP && w_state_nxt == GAP) ? r_gap + c_G_ONE : '0;
                if (w_frame_end) begin
                    r_frame_done  <= 1'b1;
                    r_frame_count <= r_frame_count + 16'd1;
                end
                if (w_load) begin
                    r_tdata      <= w_tdata;
                    r_tvalid     <= 1'b1;
                    r_tuser      <= w_sof;
                    r_tlast      <= w_line_last;
                    r_eof        <= w_frame_last;
                    r_all_loaded <= w_frame_last;
                    r_mode       <= w_mode;
                    r_solid      <= w_solid;
                    r_base.r     <= w_base.r - c_K_STEP;
                    r_base.g     <= w_base.g + c_K_STEP;
                    r_base.b     <= w_base.b - {c_K_STEP[6:0], 1'b0};
                    if (w_line_last) begin
                        r_x <= '0;
                        r_y <= w_frame_last ? '0 : r_y + c_Y_ONE;
                    end else begin
                        r_x <= r_x + c_X_STEP;
                    end
                end else if (w_xfer) begin
                    r_tvalid <= 1'b0;
                    r_tuser  <= 1'b0;
                    r_tlast  <= 1'b0;
                    r_eof    <= 1'b0;
                    if (w_frame_end) r_all_loaded <= 1'b0;
                end
            end
        end
    end

    assign m_axis_video_tdata  = r_tdata;
    assign m_axis_video_tvalid = r_tvalid;
    assign m_axis_video_tuser  = r_tuser;
    assign m_axis_video_tlast  = r_tlast;
    assign frame_done          = r_frame_done;
    assign frame_count         = r_frame_count;
    assign busy                = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_axis_video_pattern_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_axis_video_pattern_gen                                   |
// | Desc     : Directed self-checking bench for axis_video_pattern_gen.    |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module tb_axis_video_pattern_gen;

    logic        aclk = 1'b0;
    logic        aresetn, aclken, enable, en_b, en_p, sw_reset, ready;
    logic [1:0]  mode;
    logic [23:0] solid_rgb;

    logic [63:0] tdata, b_tdata, p_tdata;
    logic        tvalid, tuser, tlast, fdone, busy;
    logic        b_tvalid, b_tuser, b_tlast, b_fdone, b_busy;
    logic        p_tvalid, p_tuser, p_tlast, p_fdone, p_busy;
    logic [15:0] fcnt, b_fcnt, p_fcnt;

    int total = 0;
    int bad   = 0;

    always #5 aclk = ~aclk;

    axis_video_pattern_gen #(
        .H_ACTIVE(8), .V_ACTIVE(2), .PIX_PER_BEAT(1), .COMP_W(10),
        .TDATA_W(64), .FRAME_GAP(0), .CHK_LOG2(2)
    ) u_dut (
        .aclk(aclk), .aresetn(aresetn), .aclken(aclken), .enable(enable),
        .sw_reset(sw_reset), .mode(mode), .solid_rgb(solid_rgb),
        .m_axis_video_tdata(tdata), .m_axis_video_tvalid(tvalid),
        .m_axis_video_tready(ready), .m_axis_video_tuser(tuser),
        .m_axis_video_tlast(tlast), .frame_done(fdone), .frame_count(fcnt),
        .busy(busy)
    );

    axis_video_pattern_gen #(
        .H_ACTIVE(16), .V_ACTIVE(2), .PIX_PER_BEAT(1), .COMP_W(10),
        .TDATA_W(64), .FRAME_GAP(0), .CHK_LOG2(5)
    ) u_dut_bars (
        .aclk(aclk), .aresetn(aresetn), .aclken(aclken), .enable(en_b),
        .sw_reset(sw_reset), .mode(2'd2), .solid_rgb(solid_rgb),
        .m_axis_video_tdata(b_tdata), .m_axis_video_tvalid(b_tvalid),
        .m_axis_video_tready(ready), .m_axis_video_tuser(b_tuser),
        .m_axis_video_tlast(b_tlast), .frame_done(b_fdone), .frame_count(b_fcnt),
        .busy(b_busy)
    );

    axis_video_pattern_gen #(
        .H_ACTIVE(8), .V_ACTIVE(2), .PIX_PER_BEAT(2), .COMP_W(10),
        .TDATA_W(64), .FRAME_GAP(0), .CHK_LOG2(5)
    ) u_dut_ppb2 (
        .aclk(aclk), .aresetn(aresetn), .aclken(aclken), .enable(en_p),
        .sw_reset(sw_reset), .mode(2'd0), .solid_rgb(solid_rgb),
        .m_axis_video_tdata(p_tdata), .m_axis_video_tvalid(p_tvalid),
        .m_axis_video_tready(ready), .m_axis_video_tuser(p_tuser),
        .m_axis_video_tlast(p_tlast), .frame_done(p_fdone), .frame_count(p_fcnt),
        .busy(p_busy)
    );

    // Expected colours {r,g,b}
    logic [23:0] bar_exp [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    function automatic logic [23:0] grad(input int n);
        return {8'(255 - n), 8'(255 + n), 8'(255 - 2 * n)};
    endfunction

    // {r,g,b} -> 30-bit field, G,B,R from LSB, value in the top 8 of each 10 bits
    function automatic logic [29:0] pk(input logic [23:0] c);
        return {c[23:16], 2'b00, c[7:0], 2'b00, c[15:8], 2'b00};
    endfunction

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic get_beat(input int which, output logic [63:0] d,
                            output logic u, output logic l);
        logic        v, uu, ll, found;
        logic [63:0] dd;
        found = 1'b0;
        d = '0; u = 1'b0; l = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            case (which)
                1:       begin v = b_tvalid; dd = b_tdata; uu = b_tuser; ll = b_tlast; end
                2:       begin v = p_tvalid; dd = p_tdata; uu = p_tuser; ll = p_tlast; end
                default: begin v = tvalid;   dd = tdata;   uu = tuser;   ll = tlast;   end
            endcase
            if (v && ready && aclken) begin
                d = dd; u = uu; l = ll; found = 1'b1;
            end
            step();
        end
        total++;
        assert (found) else begin
            bad++;
            $error("FAIL beat_timeout dut=%0d observed=none expected=beat", which);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        logic        u, l;
        int          x;

        aresetn = 1'b0; aclken = 1'b1; enable = 1'b0; en_b = 1'b0; en_p = 1'b0;
        sw_reset = 1'b0; ready = 1'b1; mode = 2'd0; solid_rgb = 24'h123456;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tuser", tuser, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_fdone", fdone, 0);
        chk("rst_fcnt", fcnt, 0);
        chk("rst_busy", busy, 0);
        aresetn = 1'b1;
        step();

        // Single gradient frame, latency and framing
        enable = 1'b1;
        step();
        chk("lat_tvalid_n", tvalid, 0);
        chk("lat_busy", busy, 1);
        step();
        enable = 1'b0;
        chk("lat_tvalid_n1", tvalid, 1);
        chk("lat_tuser_n1", tuser, 1);
        for (int n = 0; n < 16; n++) begin
            get_beat(0, d, u, l);
            chk("t1_data", d, {34'b0, pk(grad(n))});
            chk("t1_tuser", u, 64'(n == 0));
            chk("t1_tlast", l, 64'(n == 7 || n == 15));
        end
        chk("t1_fdone", fdone, 1);
        chk("t1_fcnt", fcnt, 1);
        chk("t1_tvalid_off", tvalid, 0);
        step();
        chk("t1_fdone_pulse", fdone, 0);
        chk("t1_idle", busy, 0);

        // Backpressure at beat 4, then back-to-back into the next frame
        enable = 1'b1;
        for (int n = 0; n < 4; n++) begin
            get_beat(0, d, u, l);
            chk("t2_data", d, {34'b0, pk(grad(n))});
        end
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_stall_valid", tvalid, 1);
            chk("t2_stall_data", tdata, {34'b0, pk(grad(4))});
            chk("t2_stall_last", tlast, 0);
        end
        ready = 1'b1;
        for (int n = 4; n < 16; n++) begin
            get_beat(0, d, u, l);
            chk("t2_data", d, {34'b0, pk(grad(n))});
            chk("t2_tlast", l, 64'(n == 7 || n == 15));
        end
        chk("b2b_tvalid", tvalid, 1);
        chk("b2b_tuser", tuser, 1);
        chk("b2b_data", tdata, {34'b0, pk(grad(0))});
        chk("b2b_fdone", fdone, 1);
        chk("b2b_fcnt", fcnt, 2);

        // Enable dropped at beat 3: frame finishes, then idle
        for (int n = 0; n < 3; n++) begin
            get_beat(0, d, u, l);
            chk("t4_data", d, {34'b0, pk(grad(n))});
        end
        enable = 1'b0;
        for (int n = 3; n < 16; n++) begin
            get_beat(0, d, u, l);
            chk("t4_data", d, {34'b0, pk(grad(n))});
        end
        chk("t4_fcnt", fcnt, 3);
        chk("t4_tvalid", tvalid, 0);
        chk("t4_busy", busy, 0);

        // sw_reset at beat 5 (dominates a concurrent transfer)
        enable = 1'b1;
        step();
        enable = 1'b0;
        for (int n = 0; n < 5; n++) get_beat(0, d, u, l);
        chk("t3_pre_data", tdata, {34'b0, pk(grad(5))});
        sw_reset = 1'b1;
        step();
        sw_reset = 1'b0;
        chk("t3_tvalid", tvalid, 0);
        chk("t3_busy", busy, 0);
        chk("t3_fdone", fdone, 0);
        chk("t3_fcnt", fcnt, 3);
        repeat (3) step();
        chk("t3_quiet", tvalid, 0);
        enable = 1'b1;
        step();
        enable = 1'b0;
        get_beat(0, d, u, l);
        chk("t3_sof_tuser", u, 1);
        chk("t3_sof_data", d, {34'b0, pk(grad(0))});
        get_beat(0, d, u, l);
        chk("t3_data1", d, {34'b0, pk(grad(1))});
        aclken = 1'b0;
        step();
        step();
        chk("clken_valid", tvalid, 1);
        chk("clken_data", tdata, {34'b0, pk(grad(2))});
        aclken = 1'b1;
        for (int n = 2; n < 16; n++) begin
            get_beat(0, d, u, l);
            chk("t3_data", d, {34'b0, pk(grad(n))});
        end
        chk("t3_fcnt_after", fcnt, 4);

        // Checker (square 4 px); mode changed mid-frame must not take effect
        mode = 2'd3;
        enable = 1'b1;
        step();
        enable = 1'b0;
        for (int n = 0; n < 16; n++) begin
            get_beat(0, d, u, l);
            if (n == 0) mode = 2'd1;
            x = n % 8;
            chk("chk_data", d, {34'b0, pk((x < 4) ? 24'hFFFFFF : 24'h000000)});
        end
        chk("chk_fcnt", fcnt, 5);

        // Solid colour
        enable = 1'b1;
        step();
        enable = 1'b0;
        for (int n = 0; n < 16; n++) begin
            get_beat(0, d, u, l);
            chk("solid_data", d, {34'b0, pk(24'h123456)});
        end
        chk("solid_fcnt", fcnt, 6);
        mode = 2'd0;

        // Colour bars, H_ACTIVE=16
        en_b = 1'b1;
        step();
        en_b = 1'b0;
        for (int i = 0; i < 32; i++) begin
            get_beat(1, d, u, l);
            x = i % 16;
            chk("bars_data", d, {34'b0, pk(bar_exp[x / 2])});
            chk("bars_tlast", l, 64'(x == 15));
            chk("bars_tuser", u, 64'(i == 0));
        end
        chk("bars_fcnt", b_fcnt, 1);

        // Two pixels per beat gradient
        en_p = 1'b1;
        step();
        en_p = 1'b0;
        for (int j = 0; j < 8; j++) begin
            get_beat(2, d, u, l);
            chk("ppb2_data", d, {4'b0, pk(grad(2 * j + 1)), pk(grad(2 * j))});
            chk("ppb2_tlast", l, 64'(j % 4 == 3));
        end
        chk("ppb2_fcnt", p_fcnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
